// File: rtl/rx_engine_pkg.sv
// Shared types and constants for the serial-link receive framer.
package rx_engine_pkg;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_SBS  = 2'd1,
        RX_DATA = 2'd2,
        RX_GAP  = 2'd3
    } rx_state_t;

    // Start-bit-suffix digit announcing a READ_16 (prefetch) reply; truncated to the link width.
    localparam logic [3:0] RX_SBS_READ_16    = 4'b0001;
    localparam logic [3:0] TX_HEADER_READ_16 = 4'b0110;

    function automatic int rx_counter_width(input int payload_cycles);
        return $clog2(payload_cycles) + 1;
    endfunction

endpackage

// File: rtl/rx_engine_if.sv
// Request/response bundle between the link pins, the TX side and the prefetcher.
interface rx_engine_if #(
    parameter int IO_BITS = 2,
    parameter int CNT_W   = 4
);
    logic [IO_BITS-1:0] rx_pins;
    logic               req_issued;
    logic               req_is_prefetch;
    logic               rx_started;
    logic               rx_active;
    logic [IO_BITS-1:0] rx_sbs;
    logic               rx_sbs_valid;
    logic               rx_data_valid;
    logic               load_data_valid;
    logic [CNT_W-1:0]   rx_counter;
    logic               rx_done;
    logic               load_done;
    logic               rx_error;

    modport master (
        output rx_pins, req_issued, req_is_prefetch,
        input  rx_started, rx_active, rx_sbs, rx_sbs_valid, rx_data_valid,
               load_data_valid, rx_counter, rx_done, load_done, rx_error
    );

    modport slave (
        input  rx_pins, req_issued, req_is_prefetch,
        output rx_started, rx_active, rx_sbs, rx_sbs_valid, rx_data_valid,
               load_data_valid, rx_counter, rx_done, load_done, rx_error
    );
endinterface

// File: rtl/rx_order_fifo.sv
// 1-bit shift-register FIFO remembering the kind (prefetch/load) of each outstanding request.
module rx_order_fifo #(
    parameter int  DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          din,
    input  logic          pop,
    output logic          head,
    output logic [CW-1:0] count,
    output logic          full
);
    logic [DEPTH-1:0] mem;
    logic [CW-1:0]    wr_idx;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == CW'(DEPTH));
    assign head    = mem[0];
    assign pop_ok  = pop && (count != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);
    assign wr_idx  = pop_ok ? (count - CW'(1)) : count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem   <= '0;
            count <= '0;
        end else begin
            if (pop_ok)
                mem <= {1'b0, mem[DEPTH-1:1]};
            if (push_ok)
                mem[wr_idx] <= din;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/rx_engine.sv
// Receive-side framer: detects a reply start bit, checks the SBS digit and counts payload digits.
module rx_engine
    import rx_engine_pkg::*;
#(
    parameter int IO_BITS         = 2,
    parameter int PAYLOAD_CYCLES  = 8,
    parameter int MAX_OUTSTANDING = 3
) (
    input logic      clk,
    input logic      reset_n,
    rx_engine_if.slave bus
);
    localparam int                 CNT_W   = rx_counter_width(PAYLOAD_CYCLES);
    localparam int                 OCW     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]   LAST    = CNT_W'(PAYLOAD_CYCLES - 1);
    localparam logic [IO_BITS-1:0] SBS_EXP = RX_SBS_READ_16[IO_BITS-1:0];

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             kind_q;
    logic             err_q;
    logic             pop;
    logic             fifo_head;
    logic             fifo_full;
    logic [OCW-1:0]   outstanding;
    logic             sbs_bad;
    logic             overflow;

    rx_order_fifo #(.DEPTH(MAX_OUTSTANDING)) u_order (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (bus.req_issued),
        .din    (bus.req_is_prefetch),
        .pop    (pop),
        .head   (fifo_head),
        .count  (outstanding),
        .full   (fifo_full)
    );

    // Prefetch replies must carry the READ_16 suffix and load replies must not.
    assign sbs_bad  = (state_q == RX_SBS) && (fifo_head != (bus.rx_pins == SBS_EXP));
    assign overflow = bus.req_issued && fifo_full && !pop;
    assign bus.rx_error = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            kind_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == RX_SBS)
                kind_q <= fifo_head;
            err_q <= err_q | sbs_bad | overflow;
        end
    end

    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        pop                 = 1'b0;
        bus.rx_started      = 1'b0;
        bus.rx_active       = 1'b0;
        bus.rx_sbs          = '0;
        bus.rx_sbs_valid    = 1'b0;
        bus.rx_data_valid   = 1'b0;
        bus.load_data_valid = 1'b0;
        bus.rx_counter      = '0;
        bus.rx_done         = 1'b0;
        bus.load_done       = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (outstanding != '0 && !bus.rx_pins[0]) begin
                    bus.rx_started = 1'b1;
                    state_d        = RX_SBS;
                end
            end
            RX_SBS: begin
                bus.rx_active    = 1'b1;
                bus.rx_sbs_valid = 1'b1;
                bus.rx_sbs       = bus.rx_pins;
                cnt_d            = '0;
                state_d          = RX_DATA;
            end
            RX_DATA: begin
                bus.rx_active       = 1'b1;
                bus.rx_counter      = cnt_q;
                bus.rx_data_valid   = kind_q;
                bus.load_data_valid = !kind_q;
                if (cnt_q == LAST) begin
                    bus.rx_done   = kind_q;
                    bus.load_done = !kind_q;
                    pop           = 1'b1;
                    cnt_d         = '0;
                    state_d       = RX_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_GAP: begin
                state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end
endmodule
